hash_op_scheduler: RTL and testbench

Arbitrates lookup, insert and delete requesters onto the single shared operation port of the second-chance hashtable pipeline, issuing at most one operation per cycle. Enforces a credit limit on in-flight operations, propagates downstream back-pressure as the pipeline clock enable, and supports a drain (flush) sequence that stops issue until every outstanding operation has retired. Its issue outputs drive the pipeline key/data inputs and the forwarder's write/delete inputs.

---
 rtl/hash_op_scheduler.sv | 174 +++++++++++++++++
 tb/tb_hash_op_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_op_scheduler.sv
// hash_op_scheduler: round-robin arbiter of lookup/insert/delete requesters onto the
// single operation port of the hashtable pipeline, with in-flight credit limiting,
// back-pressure pass-through and a drain (flush) sequence.
module hash_op_scheduler #(
    parameter int DATA_WIDTH      = 4,
    parameter int KEY_WIDTH       = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid_i,
    output logic                  lookup_ready_o,
    input  logic [KEY_WIDTH-1:0]  lookup_key_i,
    input  logic                  insert_valid_i,
    output logic                  insert_ready_o,
    input  logic [KEY_WIDTH-1:0]  insert_key_i,
    input  logic [DATA_WIDTH-1:0] insert_data_i,
    input  logic                  delete_valid_i,
    output logic                  delete_ready_o,
    input  logic [KEY_WIDTH-1:0]  delete_key_i,
    input  logic                  pipe_ready_i,
    input  logic                  result_done_i,
    input  logic                  flush_i,
    output logic                  clk_en_o,
    output logic                  op_valid_o,
    output logic [KEY_WIDTH-1:0]  op_key_o,
    output logic [DATA_WIDTH-1:0] op_data_o,
    output logic                  op_write_o,
    output logic                  op_del_o,
    output logic [CW-1:0]         credits_o,
    output logic                  flush_done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CW-1:0] MAX_CRED = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE_CRED = CW'(1);

    state_t                state_q, state_d;
    logic [1:0]            rr_q, rr_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  err_q, err_d;
    logic                  op_valid_q, op_valid_d;
    logic [KEY_WIDTH-1:0]  op_key_q, op_key_d;
    logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
    logic                  op_write_q, op_write_d;
    logic                  op_del_q, op_del_d;

    logic [3:0] req;
    logic       grant_en;
    logic       grant_any;
    logic [1:0] grant_idx;
    logic [1:0] cand;

    // Round-robin grant: first valid requester starting at rr; nothing while reset,
    // draining, flushing, stalled downstream or out of credits.
    always_comb begin
        req       = {1'b0, delete_valid_i, insert_valid_i, lookup_valid_i};
        grant_en  = reset && (state_q == S_RUN) && !flush_i && pipe_ready_i &&
                    (credits_q != '0);
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = rr_q;
        if (grant_en) begin
            for (int k = 0; k < 3; k++) begin
                if (!grant_any && req[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
                cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            end
        end
    end

    // Next-state: issue registers, rr pointer, credit accounting, drain FSM.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        credits_d  = credits_q;
        err_d      = err_q;
        op_valid_d = op_valid_q;
        op_key_d   = op_key_q;
        op_data_d  = op_data_q;
        op_write_d = op_write_q;
        op_del_d   = op_del_q;

        if (pipe_ready_i) begin
            op_valid_d = grant_any;
            op_key_d   = '0;
            op_data_d  = '0;
            op_write_d = 1'b0;
            op_del_d   = 1'b0;
            if (grant_any) begin
                case (grant_idx)
                    2'd0:    op_key_d = lookup_key_i;
                    2'd1: begin
                        op_key_d   = insert_key_i;
                        op_data_d  = insert_data_i;
                        op_write_d = 1'b1;
                    end
                    default: begin
                        op_key_d = delete_key_i;
                        op_del_d = 1'b1;
                    end
                endcase
            end
        end

        if (grant_any) begin
            rr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end

        // A return with every credit already home is a protocol error; credits clamp.
        case ({grant_any, result_done_i})
            2'b10: credits_d = credits_q - ONE_CRED;
            2'b01: begin
                if (credits_q == MAX_CRED) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + ONE_CRED;
                end
            end
            default: credits_d = credits_q;
        endcase

        case (state_q)
            S_RUN:   if (flush_i) state_d = S_DRAIN;
            S_DRAIN: if (credits_q == MAX_CRED) state_d = S_DONE;
            S_DONE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // State registers with synchronous active-low reset; in-flight ops are discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_RUN;
            rr_q       <= 2'd0;
            credits_q  <= MAX_CRED;
            err_q      <= 1'b0;
            op_valid_q <= 1'b0;
            op_key_q   <= '0;
            op_data_q  <= '0;
            op_write_q <= 1'b0;
            op_del_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            credits_q  <= credits_d;
            err_q      <= err_d;
            op_valid_q <= op_valid_d;
            op_key_q   <= op_key_d;
            op_data_q  <= op_data_d;
            op_write_q <= op_write_d;
            op_del_q   <= op_del_d;
        end
    end

    assign lookup_ready_o = grant_any && (grant_idx == 2'd0);
    assign insert_ready_o = grant_any && (grant_idx == 2'd1);
    assign delete_ready_o = grant_any && (grant_idx == 2'd2);
    assign clk_en_o       = pipe_ready_i;
    assign op_valid_o     = op_valid_q;
    assign op_key_o       = op_key_q;
    assign op_data_o      = op_data_q;
    assign op_write_o     = op_write_q;
    assign op_del_o       = op_del_q;
    assign credits_o      = credits_q;
    assign flush_done_o   = (state_q == S_DONE);
    assign err_o          = err_q;

endmodule

// File: tb/tb_hash_op_scheduler.sv
// Testbench for hash_op_scheduler: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the scheduling rules.
module tb_hash_op_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       lv, iv, dv;
    logic [1:0] lk, ik, dk;
    logic [3:0] id;
    logic       pr, done, fl;

    logic       lookup_ready_o, insert_ready_o, delete_ready_o;
    logic       clk_en_o, op_valid_o, op_write_o, op_del_o, flush_done_o, err_o;
    logic [1:0] op_key_o;
    logic [3:0] op_data_o;
    logic [2:0] credits_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: state 0 run, 1 drain, 2 done.
    int         m_state, m_rr, m_cred;
    logic       m_err, m_opv, m_wr, m_del;
    logic [1:0] m_key;
    logic [3:0] m_data;

    hash_op_scheduler #(.DATA_WIDTH(4), .KEY_WIDTH(2), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .lookup_valid_i(lv), .lookup_ready_o(lookup_ready_o), .lookup_key_i(lk),
        .insert_valid_i(iv), .insert_ready_o(insert_ready_o), .insert_key_i(ik),
        .insert_data_i(id),
        .delete_valid_i(dv), .delete_ready_o(delete_ready_o), .delete_key_i(dk),
        .pipe_ready_i(pr), .result_done_i(done), .flush_i(fl),
        .clk_en_o(clk_en_o), .op_valid_o(op_valid_o), .op_key_o(op_key_o),
        .op_data_o(op_data_o), .op_write_o(op_write_o), .op_del_o(op_del_o),
        .credits_o(credits_o), .flush_done_o(flush_done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    wire [2:0]  act_rdy  = {lookup_ready_o, insert_ready_o, delete_ready_o};
    wire [13:0] act_regs = {op_valid_o, op_key_o, op_data_o, op_write_o, op_del_o,
                            credits_o, flush_done_o, err_o};

    function automatic int model_grant();
        if (!reset || m_state != 0 || fl || !pr || m_cred == 0) return -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_rr + k) % 3;
            if ((i == 0 && lv) || (i == 1 && iv) || (i == 2 && dv)) return i;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_ready();
        int g;
        g = model_grant();
        if (g < 0) return 3'b000;
        return 3'b100 >> g;
    endfunction

    function automatic logic [13:0] exp_regs();
        return {m_opv, m_key, m_data, m_wr, m_del, 3'(m_cred), (m_state == 2), m_err};
    endfunction

    // Advance one clock and the model by the same step; returns at the falling edge.
    task automatic tick();
        int         g, old_cred;
        logic       rst_s, pr_s, dn_s, fl_s;
        logic [1:0] key_s;
        logic [3:0] dat_s;
        g     = model_grant();
        rst_s = reset; pr_s = pr; dn_s = done; fl_s = fl;
        key_s = (g == 0) ? lk : (g == 1) ? ik : dk;
        dat_s = (g == 1) ? id : 4'd0;
        @(posedge clk);
        if (!rst_s) begin
            m_state = 0; m_rr = 0; m_cred = 4; m_err = 1'b0;
            m_opv = 1'b0; m_key = '0; m_data = '0; m_wr = 1'b0; m_del = 1'b0;
        end else begin
            old_cred = m_cred;
            if (pr_s) begin
                m_opv  = (g >= 0);
                m_key  = (g >= 0) ? key_s : 2'd0;
                m_data = (g >= 0) ? dat_s : 4'd0;
                m_wr   = (g == 1);
                m_del  = (g == 2);
            end
            if (g >= 0) m_rr = (g + 1) % 3;
            if (g >= 0 && !dn_s) m_cred = m_cred - 1;
            else if (g < 0 && dn_s) begin
                if (m_cred == 4) m_err = 1'b1;
                else m_cred = m_cred + 1;
            end
            case (m_state)
                0: if (fl_s) m_state = 1;
                1: if (old_cred == 4) m_state = 2;
                default: m_state = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lv = 0; iv = 0; dv = 0; lk = 0; ik = 0; dk = 0; id = 0;
        pr = 1; done = 0; fl = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0; lv = 1; iv = 1; dv = 1;
        #1;
        total++;
        if (act_rdy !== 3'b000) begin
            bad++; $display("FAIL reset_ready got=%b want=000", act_rdy);
        end
        tick(); tick();
        total++;
        if (act_regs !== {1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_regs got=%h want=%h", act_regs,
                            {1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0});
        end
        reset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [2:0] want_rdy;
        logic [1:0] want_wd;
        do_reset();
        lv = 1; iv = 1; dv = 1; done = 1;
        for (int c = 0; c < 9; c++) begin
            lk = 2'($urandom); ik = 2'($urandom); dk = 2'($urandom); id = 4'($urandom);
            #1;
            want_rdy = (c % 3 == 0) ? 3'b100 : (c % 3 == 1) ? 3'b010 : 3'b001;
            total++;
            if (act_rdy !== want_rdy || act_rdy !== exp_ready()) begin
                bad++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", c, act_rdy, want_rdy);
            end
            tick();
            want_wd = (c % 3 == 0) ? 2'b00 : (c % 3 == 1) ? 2'b10 : 2'b01;
            total++;
            if ({op_write_o, op_del_o} !== want_wd || credits_o !== 3'd4) begin
                bad++; $display("FAIL rr_op cyc=%0d got wd=%b cred=%0d want wd=%b cred=4",
                                c, {op_write_o, op_del_o}, credits_o, want_wd);
            end
            total++;
            if (act_regs !== exp_regs()) begin
                bad++; $display("FAIL rr_regs cyc=%0d got=%h want=%h", c, act_regs, exp_regs());
            end
        end
        idle_inputs();
    endtask

    task automatic test_credit_exhaust();
        int acc;
        do_reset();
        iv = 1;
        for (int c = 0; c < 4; c++) begin
            ik = 2'($urandom); id = 4'($urandom);
            #1;
            total++;
            if (insert_ready_o !== 1'b1) begin
                bad++; $display("FAIL cred_accept cyc=%0d got=%b want=1", c, insert_ready_o);
            end
            tick();
            total++;
            if (credits_o !== 3'(3 - c) || act_regs !== exp_regs()) begin
                bad++; $display("FAIL cred_count cyc=%0d got=%0d want=%0d", c, credits_o, 3 - c);
            end
        end
        #1;
        total++;
        if (act_rdy !== 3'b000) begin
            bad++; $display("FAIL cred_empty_ready got=%b want=000", act_rdy);
        end
        tick();
        done = 1;
        #1;
        total++;
        if (act_rdy !== 3'b000) begin
            bad++; $display("FAIL cred_return_ready got=%b want=000", act_rdy);
        end
        tick();
        done = 0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (insert_ready_o) acc++;
            total++;
            if (act_rdy !== exp_ready()) begin
                bad++; $display("FAIL cred_one_ready cyc=%0d got=%b want=%b", c, act_rdy, exp_ready());
            end
            tick();
        end
        total++;
        if (acc != 1 || credits_o !== 3'd0) begin
            bad++; $display("FAIL cred_one_more got accepts=%0d cred=%0d want 1 and 0", acc, credits_o);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        lv = 1; iv = 1; dv = 1; done = 1;
        for (int c = 0; c < 2; c++) begin
            lk = 2'($urandom); ik = 2'($urandom); id = 4'($urandom); dk = 2'($urandom);
            #1;
            tick();
        end
        pr = 0;
        for (int c = 0; c < 3; c++) begin
            lk = 2'($urandom); ik = 2'($urandom); id = 4'($urandom); dk = 2'($urandom);
            #1;
            total++;
            if (act_rdy !== 3'b000 || clk_en_o !== 1'b0) begin
                bad++; $display("FAIL bp_stall cyc=%0d got rdy=%b en=%b want 000 0", c, act_rdy, clk_en_o);
            end
            tick();
            total++;
            if (act_regs !== exp_regs() || op_write_o !== 1'b1) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", c, act_regs, exp_regs());
            end
        end
        pr = 1;
        #1;
        total++;
        if (act_rdy !== 3'b001 || clk_en_o !== 1'b1) begin
            bad++; $display("FAIL bp_resume got rdy=%b en=%b want 001 1", act_rdy, clk_en_o);
        end
        tick();
        total++;
        if (act_regs !== exp_regs() || op_del_o !== 1'b1) begin
            bad++; $display("FAIL bp_resume_op got=%h want=%h", act_regs, exp_regs());
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        int fd_cnt, fd_cyc, acc_cyc;
        do_reset();
        iv = 1;
        for (int c = 0; c < 3; c++) begin
            #1; tick();
        end
        lv = 1; fl = 1;
        #1;
        total++;
        if (act_rdy !== 3'b000) begin
            bad++; $display("FAIL flush_no_accept got=%b want=000", act_rdy);
        end
        tick();
        fl = 0;
        fd_cnt = 0; fd_cyc = -1; acc_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            done = (c == 2 || c == 4 || c == 6);
            #1;
            if (flush_done_o) begin fd_cnt++; fd_cyc = c; end
            if (act_rdy != 3'b000 && acc_cyc < 0) acc_cyc = c;
            total++;
            if (act_rdy !== exp_ready()) begin
                bad++; $display("FAIL flush_ready cyc=%0d got=%b want=%b", c, act_rdy, exp_ready());
            end
            tick();
            total++;
            if (act_regs !== exp_regs()) begin
                bad++; $display("FAIL flush_regs cyc=%0d got=%h want=%h", c, act_regs, exp_regs());
            end
        end
        total++;
        if (fd_cnt != 1 || fd_cyc != 8 || acc_cyc != 9) begin
            bad++; $display("FAIL flush_seq got pulses=%0d at=%0d accept=%0d want 1 8 9",
                            fd_cnt, fd_cyc, acc_cyc);
        end
        idle_inputs();
    endtask

    task automatic test_overflow_err();
        do_reset();
        done = 1;
        tick();
        done = 0;
        total++;
        if (credits_o !== 3'd4 || err_o !== 1'b1) begin
            bad++; $display("FAIL ovf_set got cred=%0d err=%b want 4 1", credits_o, err_o);
        end
        for (int c = 0; c < 5; c++) tick();
        total++;
        if (err_o !== 1'b1 || act_regs !== exp_regs()) begin
            bad++; $display("FAIL ovf_sticky got err=%b want 1", err_o);
        end
        reset = 0;
        tick();
        reset = 1;
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL ovf_clear got err=%b want 0", err_o);
        end
    endtask

    task automatic test_reset_mid_drain();
        int fd_cnt;
        do_reset();
        iv = 1;
        tick(); tick();
        iv = 0; fl = 1;
        tick();
        fl = 0;
        tick();
        reset = 0;
        tick();
        reset = 1;
        total++;
        if (credits_o !== 3'd4 || op_valid_o !== 1'b0) begin
            bad++; $display("FAIL rdrain_state got cred=%0d opv=%b want 4 0", credits_o, op_valid_o);
        end
        fd_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (flush_done_o) fd_cnt++;
            tick();
        end
        total++;
        if (fd_cnt != 0) begin
            bad++; $display("FAIL rdrain_no_pulse got=%0d want=0", fd_cnt);
        end
        lv = 1; iv = 1; dv = 1;
        #1;
        total++;
        if (act_rdy !== 3'b100) begin
            bad++; $display("FAIL rdrain_rr0 got=%b want=100", act_rdy);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            lv = 1'($urandom); iv = 1'($urandom); dv = 1'($urandom);
            lk = 2'($urandom); ik = 2'($urandom); dk = 2'($urandom); id = 4'($urandom);
            pr = ($urandom % 4) != 0;
            done = (m_cred < 4) ? 1'($urandom) : (($urandom % 16) == 0);
            fl = ($urandom % 20) == 0;
            #1;
            total++;
            if (act_rdy !== exp_ready() || clk_en_o !== pr) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b en=%b want=%b en=%b",
                                c, act_rdy, clk_en_o, exp_ready(), pr);
            end
            tick();
            total++;
            if (act_regs !== exp_regs()) begin
                bad++; $display("FAIL rand_regs cyc=%0d got=%h want=%h", c, act_regs, exp_regs());
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        m_state = 0; m_rr = 0; m_cred = 4; m_err = 0;
        m_opv = 0; m_key = 0; m_data = 0; m_wr = 0; m_del = 0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_credit_exhaust();
        test_backpressure();
        test_flush();
        test_overflow_err();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
